pipe_ctrl: RTL

- Parametrised pipeline hazard controller. Generalises the single EX-stall control to N stages.
- Per-stage stall requests are merged into per-stage freeze signals. Redirect flushes are sequenced through an FSM that issues a PC redirect, and a debug halt/resume mode is provided.
- A watchdog counter flags stalls that persist too long.
- Sits between the pipeline stages and the fetch unit. Stage 0 = IF, stage NUM_STAGES-1 = WB.

---
 rtl/pipe_ctrl_pkg.sv | 16 +
 rtl/stall_watchdog.sv | 23 ++
 rtl/pipe_ctrl.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  localparam int STG_IF  = 0;
  localparam int STG_ID  = 1;
  localparam int STG_EX  = 2;
  localparam int STG_MEM = 3;
  localparam int STG_WB  = 4;

endpackage

// File: rtl/stall_watchdog.sv
// Saturating consecutive-stall counter with a timeout compare; STALL_TIMEOUT=0 disables it.
module stall_watchdog #(
  parameter int STALL_TIMEOUT = 1024,
  parameter int CNT_WIDTH     = 11
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 stall_i,
  output logic [CNT_WIDTH-1:0] count_o,
  output logic                 timeout_o
);

  localparam logic [CNT_WIDTH-1:0] LIMIT = CNT_WIDTH'(STALL_TIMEOUT);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                count_o <= '0;
    else if (!stall_i)        count_o <= '0;
    else if (count_o != LIMIT) count_o <= count_o + 1'b1;
  end

  assign timeout_o = (STALL_TIMEOUT != 0) && (count_o == LIMIT);

endmodule

// File: rtl/pipe_ctrl.sv
// N-stage hazard controller: stall merge, redirect flush sequencing, debug halt, stall watchdog.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int NUM_STAGES    = 5,
  parameter int ADDR_WIDTH    = 32,
  parameter int FLUSH_CYCLES  = 1,
  parameter int STALL_TIMEOUT = 1024,
  parameter int CNT_WIDTH     = ($clog2(STALL_TIMEOUT + 1) < 1) ? 1 : $clog2(STALL_TIMEOUT + 1),
  parameter int SRC_WIDTH     = $clog2(NUM_STAGES)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NUM_STAGES-1:0] stallreq_i,
  input  logic                  flushreq_i,
  input  logic [SRC_WIDTH-1:0]  flush_src_i,
  input  logic [ADDR_WIDTH-1:0] flush_pc_i,
  input  logic                  halt_req_i,
  input  logic                  resume_i,
  output logic [NUM_STAGES-1:0] stall_o,
  output logic [NUM_STAGES-1:0] flush_o,
  output logic                  redirect_valid_o,
  output logic [ADDR_WIDTH-1:0] redirect_pc_o,
  output logic                  halted_o,
  output logic                  stall_timeout_o,
  output logic [CNT_WIDTH-1:0]  stall_cycles_o
);

  localparam int FCW = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES);
  localparam logic [FCW-1:0] FC_LAST = FCW'(FLUSH_CYCLES - 1);

  state_e                state_q, state_d;
  logic [SRC_WIDTH-1:0]  src_q, src_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [FCW-1:0]        fcnt_q, fcnt_d;
  logic                  hpend_q, hpend_d;
  logic                  pulse;
  logic [NUM_STAGES-1:0] base_stall;

  // Stages at or below the flush source (younger instructions) get killed.
  function automatic logic [NUM_STAGES-1:0] upto(input logic [SRC_WIDTH-1:0] s);
    logic [NUM_STAGES-1:0] m;
    for (int j = 0; j < NUM_STAGES; j++) m[j] = (j <= int'(s));
    return m;
  endfunction

  always_comb begin
    logic acc;
    acc        = 1'b0;
    base_stall = '0;
    for (int j = NUM_STAGES - 1; j >= 0; j--) begin
      acc           = acc | stallreq_i[j];
      base_stall[j] = acc;
    end
  end

  always_comb begin
    stall_o = base_stall;
    if (rst_i) stall_o = '0;
    else begin
      case (state_q)
        ST_FLUSH: stall_o = base_stall & ~upto(src_q);
        ST_HALT:  stall_o = '1;
        default:  stall_o = base_stall;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    pc_d    = pc_q;
    fcnt_d  = fcnt_q;
    hpend_d = hpend_q;
    pulse   = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (flushreq_i) begin
          state_d = ST_FLUSH;
          src_d   = flush_src_i;
          pc_d    = flush_pc_i;
          fcnt_d  = '0;
          pulse   = 1'b1;
          hpend_d = halt_req_i;
        end else if (halt_req_i) begin
          state_d = ST_HALT;
        end
      end
      ST_FLUSH: begin
        hpend_d = hpend_q | halt_req_i;
        // Only an older requester survives the flush in progress.
        if (flushreq_i && (flush_src_i > src_q)) begin
          src_d  = flush_src_i;
          pc_d   = flush_pc_i;
          fcnt_d = '0;
          pulse  = 1'b1;
        end else if (fcnt_q == FC_LAST) begin
          state_d = hpend_d ? ST_HALT : ST_RUN;
          hpend_d = 1'b0;
        end else begin
          fcnt_d = fcnt_q + 1'b1;
        end
      end
      ST_HALT: begin
        if (resume_i) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q          <= ST_RUN;
      src_q            <= '0;
      pc_q             <= '0;
      fcnt_q           <= '0;
      hpend_q          <= 1'b0;
      flush_o          <= '0;
      redirect_valid_o <= 1'b0;
      redirect_pc_o    <= '0;
      halted_o         <= 1'b0;
    end else begin
      state_q          <= state_d;
      src_q            <= src_d;
      pc_q             <= pc_d;
      fcnt_q           <= fcnt_d;
      hpend_q          <= hpend_d;
      flush_o          <= (state_d == ST_FLUSH) ? upto(src_d) : '0;
      redirect_valid_o <= pulse;
      if (pulse) redirect_pc_o <= pc_d;
      halted_o         <= (state_d == ST_HALT);
    end
  end

  stall_watchdog #(
    .STALL_TIMEOUT (STALL_TIMEOUT),
    .CNT_WIDTH     (CNT_WIDTH)
  ) u_wd (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .stall_i   ((state_q == ST_RUN) && base_stall[0]),
    .count_o   (stall_cycles_o),
    .timeout_o (stall_timeout_o)
  );

endmodule
